// File: rtl/dds_ser_load.sv
// dds_ser_load: serial-mode init and 40-bit word loader for an AD985x-style DDS.
// Every pin-facing output is a flop, loaded from the next-cycle state so that the pins never glitch.
module dds_ser_load #(
    parameter int DIV     = 2,
    parameter int RST_CYC = 8
) (
    input  logic        ddsclkin,
    input  logic        rst_n,
    input  logic        init,
    input  logic        load,
    input  logic [31:0] freq_word,
    input  logic [4:0]  phase,
    output logic        busy,
    output logic        done,
    output logic        ddsreset,
    output logic        ddswclk,
    output logic        ddsfqud,
    output logic        ddsdata
);
    typedef enum logic [2:0] {IDLE, RST, ENW, ENF, SHIFT, UPD, FIN} state_t;

    localparam logic [8:0] D  = 9'(DIV);
    localparam logic [8:0] P2 = 9'(2 * DIV - 1);
    localparam logic [8:0] RC = 9'(RST_CYC);
    localparam logic [8:0] RL = 9'(RST_CYC + DIV - 1);

    state_t      state, nxt;
    logic [8:0]  cnt, cnt_d;
    logic [5:0]  bitcnt, bit_d;
    logic [39:0] sr, sr_d;
    logic        last, reset_d, wclk_d, fqud_d, data_d;

    assign last = cnt == ((state == RST) ? RL : P2);

    always_ff @(posedge ddsclkin or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            bitcnt   <= '0;
            sr       <= '0;
            ddsreset <= 1'b0;
            ddswclk  <= 1'b0;
            ddsfqud  <= 1'b0;
            ddsdata  <= 1'b0;
        end else begin
            state    <= nxt;
            cnt      <= cnt_d;
            bitcnt   <= bit_d;
            sr       <= sr_d;
            ddsreset <= reset_d;
            ddswclk  <= wclk_d;
            ddsfqud  <= fqud_d;
            ddsdata  <= data_d;
        end
    end

    always_comb begin
        nxt   = state;
        cnt_d = cnt + 9'd1;
        bit_d = bitcnt;
        sr_d  = sr;
        case (state)
            IDLE: begin
                if (init) begin
                    nxt = RST;
                end else if (load) begin
                    nxt   = SHIFT;
                    sr_d  = {phase, 3'b000, freq_word};
                    bit_d = '0;
                end
            end
            RST:   nxt = last ? ENW : RST;
            ENW:   nxt = last ? ENF : ENW;
            ENF:   nxt = last ? FIN : ENF;
            SHIFT: begin
                if (last && bitcnt == 6'd39) begin
                    nxt = UPD;
                end else if (last) begin
                    bit_d = bitcnt + 6'd1;
                    sr_d  = {1'b0, sr[39:1]};
                end
            end
            UPD:     nxt = last ? FIN : UPD;
            FIN:     nxt = IDLE;
            default: nxt = IDLE;
        endcase
        // the phase counter restarts on every state change and at every bit boundary
        if (nxt != state || state == IDLE || (state == SHIFT && last))
            cnt_d = '0;
    end

    always_comb begin
        reset_d = nxt == RST && cnt_d < RC;
        wclk_d  = (nxt == ENW && cnt_d < D) || (nxt == SHIFT && cnt_d >= D);
        fqud_d  = (nxt == ENF || nxt == UPD) && cnt_d < D;
        data_d  = (nxt == SHIFT) ? sr_d[0] : ddsdata;
        busy    = state != IDLE && state != FIN;
        done    = state == FIN;
    end
endmodule

// File: tb/tb_dds_ser_load.sv
// tb_dds_ser_load: scoreboard bench; expected serial bits and done times are queued at stimulus
// and consumed by monitors watching ddswclk rises and done pulses.
module tb_dds_ser_load;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        init = 1'b0, load = 1'b0, load1 = 1'b0;
    logic [31:0] fw = '0, fw1 = '0;
    logic [4:0]  ph = '0, ph1 = '0;
    logic        busy, done, ddsreset, ddswclk, ddsfqud, ddsdata;
    logic        busy1, done1, rst1o, wclk1, fqud1, data1;

    int n_chk = 0, n_err = 0, cyc = 0, rises = 0;
    logic [1:0] bq[$];
    int         dq[$];
    logic       bq1[$];
    int         dq1[$];

    always #5 clk = ~clk;

    dds_ser_load u0 (
        .ddsclkin(clk), .rst_n(rst_n), .init(init), .load(load),
        .freq_word(fw), .phase(ph), .busy(busy), .done(done),
        .ddsreset(ddsreset), .ddswclk(ddswclk), .ddsfqud(ddsfqud), .ddsdata(ddsdata)
    );

    dds_ser_load #(.DIV(1), .RST_CYC(3)) u1 (
        .ddsclkin(clk), .rst_n(rst_n), .init(1'b0), .load(load1),
        .freq_word(fw1), .phase(ph1), .busy(busy1), .done(done1),
        .ddsreset(rst1o), .ddswclk(wclk1), .ddsfqud(fqud1), .ddsdata(data1)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // u0 monitor: serial bits, pulse widths, done timing
    initial begin
        logic [1:0] e;
        logic pw = 1'b0, pf = 1'b0, pr = 1'b0;
        int wrun = 0, frun = 0, rrun = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pw = 1'b0; pf = 1'b0; pr = 1'b0;
                wrun = 0; frun = 0; rrun = 0;
            end else begin
                if (ddswclk && !pw) begin
                    rises++;
                    if (bq.size() == 0) chk("wclk_extra", 1, 0);
                    else begin
                        e = bq.pop_front();
                        if (e != 2'd2) chk("bit", ddsdata, e[0]);
                    end
                end
                if (pw && !ddswclk) chk("wclk_hi", wrun, 2);
                if (pf && !ddsfqud) chk("fqud_hi", frun, 2);
                if (pr && !ddsreset) chk("reset_hi", rrun, 8);
                wrun = ddswclk ? wrun + 1 : 0;
                frun = ddsfqud ? frun + 1 : 0;
                rrun = ddsreset ? rrun + 1 : 0;
                if (done) begin
                    chk("busy_at_done", busy, 0);
                    if (dq.size() == 0) chk("done_extra", 1, 0);
                    else chk("done_lat", cyc, dq.pop_front());
                end
                pw = ddswclk; pf = ddsfqud; pr = ddsreset;
            end
        end
    end

    // u1 monitor: DIV=1 timing and bits
    initial begin
        logic pw1 = 1'b0;
        int wrun1 = 0, last1 = -1;
        forever begin
            @(negedge clk);
            if (wclk1 && !pw1) begin
                if (bq1.size() == 0) chk("wclk1_extra", 1, 0);
                else chk("bit1", data1, bq1.pop_front());
                if (last1 >= 0) chk("wclk1_period", cyc - last1, 2);
                last1 = cyc;
            end
            if (pw1 && !wclk1) chk("wclk1_hi", wrun1, 1);
            wrun1 = wclk1 ? wrun1 + 1 : 0;
            if (done1) begin
                last1 = -1;
                if (dq1.size() == 0) chk("done1_extra", 1, 0);
                else chk("done1_lat", cyc, dq1.pop_front());
            end
            pw1 = wclk1;
        end
    end

    task automatic do_load(input logic [31:0] f, input logic [4:0] p, input bit acc);
        logic [39:0] w;
        w = {p, 3'b000, f};
        @(negedge clk);
        fw = f; ph = p; load = 1'b1;
        if (acc) begin
            for (int i = 0; i < 40; i++) bq.push_back({1'b0, w[i]});
            dq.push_back(cyc + 165);
        end
        @(negedge clk);
        load = 1'b0;
        chk("busy_after_load", busy, 1);
    endtask

    task automatic do_init(input bit with_load);
        @(negedge clk);
        init = 1'b1; load = with_load; fw = 32'hFFFF_FFFF;
        bq.push_back(2'd2);
        dq.push_back(cyc + 19);
        @(negedge clk);
        init = 1'b0; load = 1'b0;
        chk("busy_after_init", busy, 1);
    endtask

    task automatic wait_empty(input int lim);
        int k = 0;
        while ((dq.size() + bq.size() + dq1.size() + bq1.size()) != 0 && k < lim) begin
            @(negedge clk);
            k++;
        end
        if (k >= lim) chk("timeout", dq.size() + bq.size() + dq1.size() + bq1.size(), 0);
        repeat (12) @(negedge clk);
    endtask

    initial begin
        int k;
        repeat (2) @(negedge clk);
        chk("rst_outs", {busy, done, ddsreset, ddswclk, ddsfqud, ddsdata}, 6'b0);
        chk("rst_outs1", {busy1, done1, rst1o, wclk1, fqud1, data1}, 6'b0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_busy", busy, 0);

        do_init(1'b0);
        wait_empty(100);

        do_load(32'h0000_0001, 5'h1F, 1'b1);
        wait_empty(400);

        do_load(32'hA5A5_A5A5, 5'h00, 1'b1);
        repeat (9) @(negedge clk);
        do_load(32'h1234_5678, 5'h15, 1'b0);
        wait_empty(400);

        do_init(1'b1);
        wait_empty(100);

        do_load(32'hFFFF_FFFF, 5'h1F, 1'b1);
        k = 0;
        while (rises < 21 + (rises - rises) && k < 0) k++;
        begin
            int r0;
            r0 = rises - (40 - bq.size());
            while (rises < r0 + 21 && k < 500) begin
                @(negedge clk);
                k++;
            end
            if (k >= 500) chk("abort_wait", rises, r0 + 21);
        end
        #1 rst_n = 1'b0;
        #1 chk("abort_outs", {busy, done, ddsreset, ddswclk, ddsfqud, ddsdata}, 6'b0);
        bq.delete();
        dq.delete();
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("abort_no_busy", busy, 0);
        do_load(32'hFFFF_FFFF, 5'h00, 1'b1);
        wait_empty(400);

        @(negedge clk);
        fw1 = 32'h1234_5678; ph1 = 5'h0A; load1 = 1'b1;
        for (int i = 0; i < 40; i++) bq1.push_back(((40'(ph1) << 35) | 40'(fw1)) >> i & 40'd1);
        dq1.push_back(cyc + 83);
        @(negedge clk);
        load1 = 1'b0;
        chk("busy1_after_load", busy1, 1);
        wait_empty(200);

        chk("queues_empty", dq.size() + bq.size() + dq1.size() + bq1.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end
endmodule
